// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill controller.
// Holds the state encoding, block geometry and counter width.
package cache_fill_fsm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_BYTES     = 16;
  localparam logic [15:0] OFFSET_MASK = ~16'(BLOCK_BYTES - 1);

  // One extra bit so the issue counter can represent "all words requested".
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Fill progress counter with synchronous clear, enable and a terminal-value flag.
// Used once for issued requests and once for received words.
module fill_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int WIDTH    = CNT_W,
  parameter int TERMINAL = WORDS_PER_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_terminal
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == WIDTH'(TERMINAL));

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: stalls the pipeline, streams one block from memory
// into the cache data array in request order, then writes the tag.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [DATA_W-1:0]                  memory_data,
  output logic                               fsm_busy,
  output logic                               mem_read_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] data_word_index,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               write_tag_array,
  output logic [ADDR_W-1:0]                  fill_base
);

  localparam int IDX_W      = $clog2(WORDS_PER_BLOCK);
  localparam int WORD_SHIFT = $clog2(DATA_W / 8);
  // Sign-extending the mask keeps every tag bit set whatever the address width.
  localparam logic [ADDR_W-1:0] BASE_MASK = ADDR_W'($signed(OFFSET_MASK));

  state_t            r_state;
  logic [ADDR_W-1:0] r_fill_base;

  logic [CNT_W-1:0]  w_issue_cnt;
  logic [IDX_W-1:0]  w_recv_cnt;
  logic              w_issue_done;
  logic              w_recv_last;
  logic              w_in_fill;
  logic              w_issue;
  logic              w_recv;
  logic              w_done;

  assign w_in_fill = (r_state == ST_FILL);
  assign w_issue   = w_in_fill & ~w_issue_done;
  assign w_recv    = w_in_fill & memory_data_valid;
  assign w_done    = w_recv & w_recv_last;

  fill_counter #(
    .WIDTH   (CNT_W),
    .TERMINAL(WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_done),
    .i_en      (w_issue),
    .o_count   (w_issue_cnt),
    .o_terminal(w_issue_done)
  );

  // The receive index never needs to reach WORDS_PER_BLOCK: the last word clears it.
  fill_counter #(
    .WIDTH   (IDX_W),
    .TERMINAL(WORDS_PER_BLOCK - 1)
  ) u_recv_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_done),
    .i_en      (w_recv),
    .o_count   (w_recv_cnt),
    .o_terminal(w_recv_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_fill_base <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (miss_detected) begin
            r_fill_base <= miss_address & BASE_MASK;
            r_state     <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_done) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Base has a cleared offset field, so OR-ing the word offset never carries into the tag.
  assign memory_address   = w_issue ? (r_fill_base | (ADDR_W'(w_issue_cnt) << WORD_SHIFT)) : '0;
  assign fsm_busy         = w_in_fill | miss_detected;
  assign mem_read_en      = w_issue;
  assign write_data_array = w_recv;
  assign data_word_index  = w_recv_cnt;
  assign fill_data        = memory_data;
  assign write_tag_array  = w_done;
  assign fill_base        = r_fill_base;

endmodule
